// File: rtl/pdp1_fiodec_pkg.sv
// Shared definitions for the PDP-1 keyboard encoder: FSM states, FIODEC
// control codes and the ASCII-to-FIODEC translation table.
package pdp1_fiodec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        SEND_SHIFT,
        SEND_CHAR,
        ECHO
    } state_e;

    typedef enum logic {
        CASE_LOWER = 1'b0,
        CASE_UPPER = 1'b1
    } case_e;

    localparam logic [5:0] LOWERCASE       = 6'o72;
    localparam logic [5:0] UPPERCASE       = 6'o74;
    localparam logic [5:0] CARRIAGE_RETURN = 6'o77;
    localparam logic [5:0] TAB             = 6'o36;
    localparam logic [5:0] BACKSPACE       = 6'o75;

    typedef struct packed {
        logic       valid;
        logic       needs_case;
        case_e      fcase;
        logic [5:0] code;
    } fiodec_t;

    function automatic fiodec_t fio_entry(input logic       needs_case,
                                          input case_e      fcase,
                                          input logic [5:0] code);
        fiodec_t e;
        e.valid      = 1'b1;
        e.needs_case = needs_case;
        e.fcase      = fcase;
        e.code       = code;
        return e;
    endfunction

    function automatic fiodec_t ascii_to_fiodec(input logic [7:0] a);
        fiodec_t    r;
        logic [7:0] lc;
        case_e      lcase;
        r     = '0;
        lc    = a | 8'h20;
        lcase = a[5] ? CASE_LOWER : CASE_UPPER;
        if (a inside {[8'h41:8'h5A], [8'h61:8'h7A]}) begin
            // Letters share one code in both cases; only the shift state differs
            if (lc <= 8'h69)      r = fio_entry(1'b1, lcase, 6'o61 + 6'(lc - 8'h61));
            else if (lc <= 8'h72) r = fio_entry(1'b1, lcase, 6'o41 + 6'(lc - 8'h6A));
            else                  r = fio_entry(1'b1, lcase, 6'o22 + 6'(lc - 8'h73));
        end else if (a inside {[8'h31:8'h39]}) begin
            r = fio_entry(1'b1, CASE_LOWER, 6'(a - 8'h30));
        end else begin
            case (a)
                8'h20:        r = fio_entry(1'b0, CASE_LOWER, 6'o00);
                8'h0A, 8'h0D: r = fio_entry(1'b0, CASE_LOWER, CARRIAGE_RETURN);
                8'h09:        r = fio_entry(1'b0, CASE_LOWER, TAB);
                8'h08:        r = fio_entry(1'b0, CASE_LOWER, BACKSPACE);
                8'h30:        r = fio_entry(1'b1, CASE_LOWER, 6'o20);
                8'h2F:        r = fio_entry(1'b1, CASE_LOWER, 6'o21);
                8'h3F:        r = fio_entry(1'b1, CASE_UPPER, 6'o21);
                8'h2C:        r = fio_entry(1'b1, CASE_LOWER, 6'o33);
                8'h3D:        r = fio_entry(1'b1, CASE_UPPER, 6'o33);
                8'h2D:        r = fio_entry(1'b1, CASE_LOWER, 6'o54);
                8'h2B:        r = fio_entry(1'b1, CASE_UPPER, 6'o54);
                8'h29:        r = fio_entry(1'b1, CASE_LOWER, 6'o55);
                8'h5D:        r = fio_entry(1'b1, CASE_UPPER, 6'o55);
                8'h28:        r = fio_entry(1'b1, CASE_LOWER, 6'o57);
                8'h5B:        r = fio_entry(1'b1, CASE_UPPER, 6'o57);
                8'h2E:        r = fio_entry(1'b1, CASE_LOWER, 6'o73);
                8'h2A:        r = fio_entry(1'b1, CASE_UPPER, 6'o73);
                8'h7C:        r = fio_entry(1'b1, CASE_UPPER, 6'o56);
                8'h5F:        r = fio_entry(1'b1, CASE_UPPER, 6'o40);
                8'h22:        r = fio_entry(1'b1, CASE_UPPER, 6'o01);
                8'h27:        r = fio_entry(1'b1, CASE_UPPER, 6'o02);
                8'h7E:        r = fio_entry(1'b1, CASE_UPPER, 6'o03);
                8'h3C:        r = fio_entry(1'b1, CASE_UPPER, 6'o07);
                8'h3E:        r = fio_entry(1'b1, CASE_UPPER, 6'o10);
                8'h5E:        r = fio_entry(1'b1, CASE_UPPER, 6'o11);
                default:      r = '0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/pdp1_kbd_fifo.sv
// Synchronous FIFO with registered read data, buffering keyboard bytes
// while the encoder waits on the PDP handshake.
module pdp1_kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] data_q;
    logic             do_push;
    logic             do_pop;

    // One extra lap bit on each pointer tells a full FIFO from an empty one
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = data_q;

    // NOTE: storage is deliberately not reset; the pointers alone say which
    // entries are live, and non-blocking writes make every register sample
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            data_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_INC;
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_INC;
                data_q   <= mem_q[rd_ptr_q[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/pdp1_kbd_fiodec_encoder.sv
// ASCII keyboard to PDP-1 FIODEC encoder: buffers bytes, inserts case shifts,
// hands codes over with a valid/ack handshake and strobes an echo to the display.
module pdp1_kbd_fiodec_encoder
    import pdp1_fiodec_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int STROBE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ascii_in,
    input  logic       ascii_valid,
    output logic [6:0] char_out,
    output logic       char_valid,
    input  logic       char_ack,
    output logic [6:0] char_echo,
    output logic       have_keyboard_data,
    output logic       fifo_overflow
);

    localparam int               CNT_W     = $clog2(STROBE_CYCLES + 2) + 1;
    localparam logic [CNT_W-1:0] HKD_LAST  = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ECHO_LAST = CNT_W'(STROBE_CYCLES + 1);

    state_e           state_q, state_d;
    state_e           ret_q, ret_d;
    case_e            case_q, case_d;
    case_e            pend_case_q, pend_case_d;
    logic [5:0]       pend_code_q, pend_code_d;
    logic [5:0]       out_q, out_d;
    logic [5:0]       echo_q, echo_d;
    logic             valid_q, valid_d;
    logic             hkd_q, hkd_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_data;
    fiodec_t          lut;
    logic [5:0]       send_code;

    pdp1_kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (ascii_valid),
        .data_i  (ascii_in),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign lut       = ascii_to_fiodec(fifo_data);
    assign send_code = (state_q == SEND_SHIFT)
                     ? ((pend_case_q == CASE_UPPER) ? UPPERCASE : LOWERCASE)
                     : pend_code_q;

    always_comb begin
        // NOTE: every next-state value takes its hold value first, so no
        // branch of the case below can leave a signal unassigned (no latch).
        state_d     = state_q;
        ret_d       = ret_q;
        case_d      = case_q;
        pend_case_d = pend_case_q;
        pend_code_d = pend_code_q;
        out_d       = out_q;
        echo_d      = echo_q;
        valid_d     = valid_q;
        hkd_d       = hkd_q;
        cnt_d       = cnt_q;
        fifo_pop    = 1'b0;
        ovf_d       = ovf_q | (ascii_valid & fifo_full);

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                if (!lut.valid) begin
                    state_d = IDLE;
                end else begin
                    pend_case_d = lut.fcase;
                    pend_code_d = lut.code;
                    state_d     = (lut.needs_case && (lut.fcase != case_q)) ? SEND_SHIFT : SEND_CHAR;
                end
            end
            SEND_SHIFT, SEND_CHAR: begin
                // Valid rises one cycle after entry; ack only counts once valid is up
                if (!valid_q) begin
                    valid_d = 1'b1;
                    out_d   = send_code;
                end else if (char_ack) begin
                    valid_d = 1'b0;
                    echo_d  = out_q;
                    hkd_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ECHO;
                    if (state_q == SEND_SHIFT) begin
                        case_d = pend_case_q;
                        ret_d  = SEND_CHAR;
                    end else begin
                        ret_d  = IDLE;
                    end
                end
            end
            ECHO: begin
                // Strobe high STROBE_CYCLES, then two low cycles before moving on
                cnt_d = cnt_q + CNT_W'(1);
                hkd_d = (cnt_q < HKD_LAST);
                if (cnt_q == ECHO_LAST) state_d = ret_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ret_q       <= IDLE;
            case_q      <= CASE_LOWER;
            pend_case_q <= CASE_LOWER;
            pend_code_q <= '0;
            out_q       <= '0;
            echo_q      <= '0;
            valid_q     <= 1'b0;
            hkd_q       <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            case_q      <= case_d;
            pend_case_q <= pend_case_d;
            pend_code_q <= pend_code_d;
            out_q       <= out_d;
            echo_q      <= echo_d;
            valid_q     <= valid_d;
            hkd_q       <= hkd_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    assign char_out           = {1'b0, out_q};
    assign char_valid         = valid_q;
    assign char_echo          = {1'b0, echo_q};
    assign have_keyboard_data = hkd_q;
    assign fifo_overflow      = ovf_q;

endmodule

// File: tb/tb_pdp1_kbd_fiodec_encoder.sv
// Scoreboard bench for the PDP-1 keyboard FIODEC encoder: directed ASCII
// bytes with hand-derived FIODEC sequences, checked by an independent monitor.
module tb_pdp1_kbd_fiodec_encoder;

    localparam int STROBE = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ascii_in = 8'h00;
    logic       ascii_valid = 1'b0;
    logic       char_ack = 1'b0;
    logic [6:0] char_out;
    logic       char_valid;
    logic [6:0] char_echo;
    logic       have_keyboard_data;
    logic       fifo_overflow;

    int n_checks = 0;
    int n_pass = 0;
    int exp_total = 0;
    int xfer_count = 0;
    int strobe_count = 0;
    logic [6:0] exp_q[$];

    // Monitor state
    logic       prev_valid, prev_ack, prev_acc, hkd_prev;
    logic [6:0] prev_out, last_acc;
    int         hi_cnt, lo_cnt;

    pdp1_kbd_fiodec_encoder #(
        .FIFO_DEPTH    (8),
        .STROBE_CYCLES (STROBE)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ascii_in           (ascii_in),
        .ascii_valid        (ascii_valid),
        .char_out           (char_out),
        .char_valid         (char_valid),
        .char_ack           (char_ack),
        .char_echo          (char_echo),
        .have_keyboard_data (have_keyboard_data),
        .fifo_overflow      (fifo_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0o, expected %0o", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        ascii_in    = b;
        ascii_valid = 1'b1;
        tick();
        ascii_valid = 1'b0;
    endtask

    task automatic want(input logic [5:0] c);
        exp_q.push_back({1'b0, c});
        exp_total++;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL %s: timeout with %0d chars outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        tick(12);
    endtask

    // Monitor: handshake protocol, scoreboard compare and echo strobe shape
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_ack   = 1'b0;
            prev_acc   = 1'b0;
            prev_out   = '0;
            hkd_prev   = 1'b0;
            hi_cnt     = 0;
            lo_cnt     = 100;
        end else begin
            if (prev_acc) begin
                check("valid_drop_after_ack", char_valid, 1'b0);
            end else if (prev_valid && !prev_ack) begin
                check("hold_valid", char_valid, 1'b1);
                check("hold_char_out", char_out, prev_out);
            end
            if (char_valid && char_ack) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_char: got %0o, expected no transfer", char_out);
                end else begin
                    check("char_out", char_out, exp_q.pop_front());
                end
                xfer_count++;
                last_acc = char_out;
            end
            if (have_keyboard_data && !hkd_prev) begin
                check("echo_low_gap", lo_cnt >= 2, 1'b1);
                check("char_echo", char_echo, last_acc);
                strobe_count++;
                hi_cnt = 1;
            end else if (have_keyboard_data) begin
                hi_cnt++;
            end else if (hkd_prev) begin
                check("strobe_width", hi_cnt, STROBE);
                lo_cnt = 1;
            end else begin
                lo_cnt++;
            end
            prev_acc   = char_valid && char_ack;
            prev_valid = char_valid;
            prev_ack   = char_ack;
            prev_out   = char_out;
            hkd_prev   = have_keyboard_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_char_out", char_out, 7'o0);
        check("rst_char_valid", char_valid, 1'b0);
        check("rst_hkd", have_keyboard_data, 1'b0);
        check("rst_overflow", fifo_overflow, 1'b0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // 'a' with ack tied high: single 061, no shift
        char_ack = 1'b1;
        send(8'h61); want(6'o61);
        drain("t1_a");

        // 'A','b': shift up, A, shift down, b
        send(8'h41); want(6'o74); want(6'o61);
        send(8'h62); want(6'o72); want(6'o62);
        drain("t2_Ab");

        // 'A','B' share one shift; case-independent chars never shift
        send(8'h41); want(6'o74); want(6'o61);
        send(8'h42); want(6'o62);
        send(8'h20); want(6'o00);
        send(8'h0A); want(6'o77);
        send(8'h0D); want(6'o77);
        send(8'h09); want(6'o36);
        send(8'h08); want(6'o75);
        drain("t3_AB_space");

        // Long ack stall in SEND_CHAR
        char_ack = 1'b0;
        send(8'h43); want(6'o63);
        tick(55);
        check("stall_valid", char_valid, 1'b1);
        char_ack = 1'b1;
        drain("t4_stall");

        // Digits lowercase, shifted punctuation uppercase
        send(8'h31); want(6'o72); want(6'o01);
        send(8'h22); want(6'o74); want(6'o01);
        send(8'h3F); want(6'o21);
        send(8'h2F); want(6'o72); want(6'o21);
        drain("t5_punct");

        // Overflow: FSM blocked on 'd', ten bytes arrive, last two dropped
        char_ack = 1'b0;
        send(8'h64); want(6'o64);
        tick(6);
        check("ovf_before", fifo_overflow, 1'b0);
        for (int i = 0; i < 10; i++) begin
            send(8'(8'h30 + i));
            if (i < 8) want(i == 0 ? 6'o20 : 6'(i));
        end
        tick();
        check("ovf_after", fifo_overflow, 1'b1);
        char_ack = 1'b1;
        drain("t6_overflow");
        check("ovf_sticky", fifo_overflow, 1'b1);

        // BEL has no FIODEC code
        send(8'h07);
        tick(20);
        check("bel_no_output", xfer_count, exp_total);

        // Minimum latency into an empty FIFO
        char_ack = 1'b0;
        send(8'h65); want(6'o65);
        tick(2);
        check("latency_3", char_valid, 1'b0);
        tick();
        check("latency_4", char_valid, 1'b1);
        char_ack = 1'b1;
        drain("t8_latency");

        // Reset mid-handshake while in upper case with bytes queued
        send(8'h45); want(6'o74); want(6'o65);
        drain("t9_E");
        char_ack = 1'b0;
        send(8'h46); want(6'o66);
        tick(6);
        check("pre_reset_valid", char_valid, 1'b1);
        send(8'h47);
        send(8'h48);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", char_valid, 1'b0);
        check("mid_rst_char_out", char_out, 7'o0);
        check("mid_rst_echo", char_echo, 7'o0);
        check("mid_rst_hkd", have_keyboard_data, 1'b0);
        check("mid_rst_overflow", fifo_overflow, 1'b0);
        exp_total -= exp_q.size();
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        char_ack = 1'b1;
        tick(30);
        check("post_rst_no_xfer", xfer_count, exp_total);
        send(8'h61); want(6'o61);
        drain("t9_post_reset_a");

        check("xfer_total", xfer_count, exp_total);
        check("strobe_total", strobe_count, exp_total);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pdp1_kbd_fiodec_encoder.md
PDP1_KBD_FIODEC_ENCODER -- requirements
Module: pdp1_kbd_fiodec_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, sets the ASCII input FIFO depth; it shall be a power of two, at least 2.
REQ-002 Parameter STROBE_CYCLES, default 4, sets the echo strobe high time in clk cycles; it shall be at least 2.
REQ-003 clk  input  1  single system clock; all logic on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ascii_in  input  8  ASCII byte from the keyboard scanner.
REQ-006 ascii_valid  input  1  one-cycle qualifier for ascii_in.
REQ-007 char_out  output  7  FIODEC code to the PDP: bit 6 = 0, bits 5:0 = code.
REQ-008 char_valid  output  1  char_out is valid; held until accepted.
REQ-009 char_ack  input  1  PDP accepts char_out.
REQ-010 char_echo  output  7  copy of the last accepted char_out, routed to the typewriter display char_in_kbd.
REQ-011 have_keyboard_data  output  1  echo strobe to the typewriter display.
REQ-012 fifo_overflow  output  1  sticky flag: an input byte was dropped because the FIFO was full.

Function
REQ-013 Each ascii_valid with a non-full FIFO shall push ascii_in; with a full FIFO the byte shall be dropped and fifo_overflow set.
REQ-014 Push and pop in the same cycle shall both take effect, and occupancy shall be unchanged.
REQ-015 The FIFO read and write pointers shall wrap modulo FIFO_DEPTH.
REQ-016 FSM states shall be IDLE, LOOKUP, SEND_SHIFT, SEND_CHAR and ECHO.
REQ-017 In IDLE, if the FIFO is non-empty, the FSM shall pop one byte and go to LOOKUP.
REQ-018 In LOOKUP, the byte shall be translated through the shared table into {valid, needs_case, case, code[5:0]}.
REQ-019 From LOOKUP, an invalid byte shall be dropped with a return to IDLE, producing no output.
REQ-020 From LOOKUP, if needs_case=1 and case differs from the current_case register, the FSM shall go to SEND_SHIFT; otherwise it shall go to SEND_CHAR.
REQ-021 SEND_SHIFT shall drive char_out = UPPERCASE (074 octal) or LOWERCASE (072 octal) with char_valid=1.
REQ-022 On char_ack in SEND_SHIFT, current_case shall update and the FSM shall go to ECHO, then continue to SEND_CHAR.
REQ-023 SEND_CHAR shall drive the translated code with char_valid=1; on char_ack the FSM shall go to ECHO and then return to IDLE.
REQ-024 char_valid shall rise the cycle after state entry.
REQ-025 char_out shall stay stable while char_valid=1 and char_ack=0; char_valid shall drop the cycle after char_ack.
REQ-026 char_ack while char_valid=0 shall be ignored.
REQ-027 ECHO shall load char_echo with the accepted code and assert have_keyboard_data for exactly STROBE_CYCLES cycles.
REQ-028 ECHO shall then hold have_keyboard_data low for at least 2 cycles before leaving, so each echo forms a distinct rising edge.
REQ-029 Case-independent characters (space, carriage return 077, tab 036, backspace 075) shall have needs_case=0 and shall never emit a shift code.
REQ-030 ASCII LF (0x0A) and CR (0x0D) shall both map to 077.
REQ-031 Letters shall map to the same code in either case: 'a' = 061 lower, 'A' = 061 upper.
REQ-032 Digits shall be lowercase ('1' = 001, '0' = 020); shifted punctuation shall use the upper case of the matching key.
REQ-033 Minimum latency from ascii_valid into an empty FIFO to char_valid, with no shift needed, shall be 4 cycles.

Reset
REQ-034 While rst_n=0: char_out=0, char_valid=0, char_echo=0, have_keyboard_data=0, fifo_overflow=0.
REQ-035 While rst_n=0: FIFO empty, FSM in IDLE, current_case=0 (lowercase, matching the display's power-on case).
REQ-036 Reset mid-handshake shall abandon the pending character; after release, no stale char_valid or strobe shall appear.

Structure
REQ-037 Package pdp1_fiodec_pkg shall hold the FSM state enum, the constants LOWERCASE, UPPERCASE, CARRIAGE_RETURN, TAB and BACKSPACE, and the ASCII-to-FIODEC lookup function.
REQ-038 The FIFO shall be one sub-module, pdp1_kbd_fifo (synchronous, registered read, full/empty outputs); translation and FSM shall stay in the top module.

Verification
REQ-039 Reset, then 'a' with char_ack tied high -> one char_out=061, no shift, have_keyboard_data high 4 cycles, char_echo=061.
REQ-040 'A' then 'b' -> char_out sequence 074, 061, 072, 062, with four distinct echo strobes.
REQ-041 'A','B' -> 074, 061, 062 only, with no repeated shift; then space -> 000 with no shift.
REQ-042 Hold char_ack low 50 cycles during SEND_CHAR -> char_out and char_valid stable throughout; one transfer after ack.
REQ-043 With char_ack low, push 10 bytes -> first 8 delivered in order, last 2 dropped, fifo_overflow=1.
REQ-044 Byte 0x07 -> no output. rst_n pulsed low while char_valid=1 -> char_valid=0 immediately, current_case=0, FIFO empty.
